// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// Free-running VGA raster timing generator. The default timing is 640x480@60
// on a 25.175 MHz pixel clock. It sits directly upstream of the screensaver
// image/animation logic. That logic consumes the coordinate, the active flag
// and the strobes to produce r/g/b. The syncs are routed unchanged to the pads.
//
// Every output is a flop, and all outputs describe the same pixel. The
// registered strobes and syncs are computed from the *next* (x,y), so they
// line up with the registered counters without any skew.
//
// Optional feature macro: VGA_SYNC_GEN_TESTPATTERN_EN
//   defined   : r/g/b carry 64-pixel colour bars (x[6], x[7], x[8]) while
//               active, and 0 otherwise. Use this for monitor bring-up.
//   undefined : r/g/b are tied to 0 and no pattern logic exists. The ports
//               stay, so the top-level wiring is identical in both builds.
//
// Ports:
//   clk          in   1   pixel clock
//   rst_n        in   1   synchronous active-low reset
//   hsync        out  1   horizontal sync, polarity set by SYNC_POL
//   vsync        out  1   vertical sync, polarity set by SYNC_POL
//   active       out  1   1 while x < H_ACTIVE and y < V_ACTIVE
//   x            out  10  pixel column, 0..H_TOTAL-1
//   y            out  10  line, 0..V_TOTAL-1
//   line_start   out  1   1 for the cycle where x == 0
//   frame_start  out  1   1 for the cycle where x == 0 and y == 0
//   frame_cnt    out  8   frame counter, increments on entry to (0,0)
//   r, g, b      out  4   bring-up test pattern (see macro above)
//
// H_TOTAL and V_TOTAL must each be <= 1024.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds are 11 bits wide so that a sync ending exactly at 1024 does
  // not wrap to zero.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap, v_wrap;
  logic       hs_window, vs_window;

  // Next raster position and the flags that describe it. The counters use
  // == compares, so any reachable value still wraps cleanly. vsync depends
  // only on y_d, so it can only change on the cycle where x becomes 0.
  always_comb begin
    h_wrap      = (x_q == H_LAST);
    v_wrap      = (y_q == V_LAST);
    x_d         = h_wrap ? 10'd0 : x_q + 10'd1;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    if (h_wrap) begin
      y_d = v_wrap ? 10'd0 : y_q + 10'd1;
      if (v_wrap) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    hs_window     = ({1'b0, x_d} >= H_SYNC_BEG) && ({1'b0, x_d} < H_SYNC_END);
    vs_window     = ({1'b0, y_d} >= V_SYNC_BEG) && ({1'b0, y_d} < V_SYNC_END);
    hsync_d       = hs_window ? SYNC_ON : SYNC_OFF;
    vsync_d       = vs_window ? SYNC_ON : SYNC_OFF;
    active_d      = ({1'b0, x_d} < H_ACT_END) && ({1'b0, y_d} < V_ACT_END);
    line_start_d  = (x_d == 10'd0);
    frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
  end

  // The reset state is the last pixel of a frame. The first edge after
  // release therefore lands on (0,0), with frame_start set and frame_cnt at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      frame_cnt_q   <= 8'd0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_cnt_q   <= frame_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_cnt   = frame_cnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_GEN_TESTPATTERN_EN
  logic [3:0] r_q, r_d;
  logic [3:0] g_q, g_d;
  logic [3:0] b_q, b_d;

  // The colour bars come from the next x, so they land together with x_q.
  always_comb begin
    r_d = 4'd0;
    g_d = 4'd0;
    b_d = 4'd0;
    if (active_d) begin
      r_d = {4{x_d[6]}};
      g_d = {4{x_d[7]}};
      b_d = {4{x_d[8]}};
    end
  end

  // Pattern registers, cleared with the rest of the raster state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= 4'd0;
      g_q <= 4'd0;
      b_q <= 4'd0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;
`else
  assign r = 4'd0;
  assign g = 4'd0;
  assign b = 4'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Two instances share one clock.
//   dutA : default 640x480 timing, active-low syncs. It exercises reset and
//          one full line, plus the colour bars when the pattern macro is set.
//   dutB : a tiny raster, 16x10 total and active-high syncs. It makes full
//          frames and a 256-frame counter wrap affordable. Its timing:
//            H: 8 active, 2 FP, 4 sync, 2 BP -> sync at x = 10..13
//            V: 5 active, 1 FP, 2 sync, 2 BP -> sync at y = 6..7
//            frame = 160 cycles
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  logic       clk;
  logic       rstA_n, rstB_n;

  logic       hsA, vsA, actA, lsA, fsA;
  logic [9:0] xA, yA;
  logic [7:0] fcA;
  logic [3:0] rA, gA, bA;

  logic       hsB, vsB, actB, lsB, fsB;
  logic [9:0] xB, yB;
  logic [7:0] fcB;
  logic [3:0] rB, gB, bB;

  int vecs;
  int errs;

  vga_sync_gen dutA (
    .clk(clk), .rst_n(rstA_n), .hsync(hsA), .vsync(vsA), .active(actA),
    .x(xA), .y(yA), .line_start(lsA), .frame_start(fsA), .frame_cnt(fcA),
    .r(rA), .g(gA), .b(bA)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1)
  ) dutB (
    .clk(clk), .rst_n(rstB_n), .hsync(hsB), .vsync(vsB), .active(actB),
    .x(xB), .y(yB), .line_start(lsB), .frame_start(fsB), .frame_cnt(fcB),
    .r(rB), .g(gB), .b(bB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Power-on reset on both instances, then the first edge after release.
  task automatic test_reset();
    rstA_n = 1'b0;
    rstB_n = 1'b0;
    repeat (3) stepCycle();
    vecs += 10;
    if (xA !== 10'd799) begin errs++; $display("[TB] FAIL rstA_x: got %0d expected 799", xA); end
    if (yA !== 10'd524) begin errs++; $display("[TB] FAIL rstA_y: got %0d expected 524", yA); end
    if (actA !== 1'b0) begin errs++; $display("[TB] FAIL rstA_active: got %b expected 0", actA); end
    if (hsA !== 1'b1 || vsA !== 1'b1) begin errs++; $display("[TB] FAIL rstA_sync: got hs=%b vs=%b expected 1/1", hsA, vsA); end
    if (fcA !== 8'd0) begin errs++; $display("[TB] FAIL rstA_fcnt: got %0d expected 0", fcA); end
    if (lsA !== 1'b0 || fsA !== 1'b0) begin errs++; $display("[TB] FAIL rstA_strobes: got ls=%b fs=%b expected 0/0", lsA, fsA); end
    if ({rA, gA, bA} !== 12'h000) begin errs++; $display("[TB] FAIL rstA_rgb: got %h expected 000", {rA, gA, bA}); end
    if (xB !== 10'd15 || yB !== 10'd9) begin errs++; $display("[TB] FAIL rstB_xy: got %0d,%0d expected 15,9", xB, yB); end
    if (hsB !== 1'b0 || vsB !== 1'b0) begin errs++; $display("[TB] FAIL rstB_sync: got hs=%b vs=%b expected 0/0", hsB, vsB); end
    if (fcB !== 8'd0) begin errs++; $display("[TB] FAIL rstB_fcnt: got %0d expected 0", fcB); end

    rstA_n = 1'b1;
    rstB_n = 1'b1;
    stepCycle();
    vecs += 4;
    if (xA !== 10'd0 || yA !== 10'd0) begin errs++; $display("[TB] FAIL relA_xy: got %0d,%0d expected 0,0", xA, yA); end
    if (fsA !== 1'b1 || lsA !== 1'b1 || actA !== 1'b1) begin errs++; $display("[TB] FAIL relA_flags: got fs=%b ls=%b act=%b expected 1/1/1", fsA, lsA, actA); end
    if (fcA !== 8'd1) begin errs++; $display("[TB] FAIL relA_fcnt: got %0d expected 1", fcA); end
    if (xB !== 10'd0 || yB !== 10'd0 || fsB !== 1'b1 || fcB !== 8'd1) begin
      errs++; $display("[TB] FAIL relB_state: got x=%0d y=%0d fs=%b fc=%0d expected 0,0,1,1", xB, yB, fsB, fcB);
    end
  endtask

  // One full default line starting from (0,0). Checks every cycle and then
  // the edge positions.
  task automatic test_hline();
    int expX, expY;
    logic expHs, expAct, prevHs, prevAct;
    int hsFall, hsRise, actFall;
    hsFall = -1; hsRise = -1; actFall = -1;
    prevHs = hsA; prevAct = actA;
    for (int i = 1; i <= 800; i++) begin
      stepCycle();
      expX   = i % 800;
      expY   = (i == 800) ? 1 : 0;
      expHs  = !((expX >= 656) && (expX < 752));
      expAct = (expX < 640);
      vecs += 5;
      if (xA !== 10'(expX) || yA !== 10'(expY)) begin errs++; $display("[TB] FAIL line_xy: got %0d,%0d expected %0d,%0d", xA, yA, expX, expY); end
      if (hsA !== expHs) begin errs++; $display("[TB] FAIL line_hsync x=%0d: got %b expected %b", expX, hsA, expHs); end
      if (actA !== expAct) begin errs++; $display("[TB] FAIL line_active x=%0d: got %b expected %b", expX, actA, expAct); end
      if (lsA !== (expX == 0)) begin errs++; $display("[TB] FAIL line_start x=%0d: got %b", expX, lsA); end
      if (vsA !== 1'b1) begin errs++; $display("[TB] FAIL line_vsync x=%0d: got %b expected 1", expX, vsA); end
`ifdef VGA_SYNC_GEN_TESTPATTERN_EN
      if (expX == 64) begin
        vecs++;
        if ({rA, gA, bA} !== 12'hF00) begin errs++; $display("[TB] FAIL pat_x64: got %h expected F00", {rA, gA, bA}); end
      end
      if (expX == 448) begin
        vecs++;
        if ({rA, gA, bA} !== 12'hFFF) begin errs++; $display("[TB] FAIL pat_x448: got %h expected FFF", {rA, gA, bA}); end
      end
      if (expX == 700) begin
        vecs++;
        if ({rA, gA, bA} !== 12'h000) begin errs++; $display("[TB] FAIL pat_x700: got %h expected 000", {rA, gA, bA}); end
      end
`else
      vecs++;
      if ({rA, gA, bA} !== 12'h000) begin errs++; $display("[TB] FAIL rgb_off x=%0d: got %h expected 000", expX, {rA, gA, bA}); end
`endif
      if (prevHs === 1'b1 && hsA === 1'b0) hsFall = expX;
      if (prevHs === 1'b0 && hsA === 1'b1) hsRise = expX;
      if (prevAct === 1'b1 && actA === 1'b0) actFall = expX;
      prevHs = hsA; prevAct = actA;
    end
    vecs += 3;
    if (hsFall != 656) begin errs++; $display("[TB] FAIL hsync_fall: got %0d expected 656", hsFall); end
    if (hsRise != 752) begin errs++; $display("[TB] FAIL hsync_rise: got %0d expected 752", hsRise); end
    if (actFall != 640) begin errs++; $display("[TB] FAIL active_fall: got %0d expected 640", actFall); end
  endtask

  // Re-reset the small raster, then walk one full frame of 160 cycles.
  task automatic test_frame();
    int expX, expY;
    logic prevVs;
    rstB_n = 1'b0;
    repeat (3) stepCycle();
    rstB_n = 1'b1;
    stepCycle();
    prevVs = vsB;
    for (int i = 1; i <= 160; i++) begin
      stepCycle();
      expX = i % 16;
      expY = (i / 16) % 10;
      vecs += 6;
      if (xB !== 10'(expX) || yB !== 10'(expY)) begin errs++; $display("[TB] FAIL frm_xy: got %0d,%0d expected %0d,%0d", xB, yB, expX, expY); end
      if (hsB !== ((expX >= 10) && (expX <= 13))) begin errs++; $display("[TB] FAIL frm_hsync %0d,%0d: got %b", expX, expY, hsB); end
      if (vsB !== ((expY >= 6) && (expY <= 7))) begin errs++; $display("[TB] FAIL frm_vsync %0d,%0d: got %b", expX, expY, vsB); end
      if (actB !== ((expX < 8) && (expY < 5))) begin errs++; $display("[TB] FAIL frm_active %0d,%0d: got %b", expX, expY, actB); end
      if (fsB !== ((expX == 0) && (expY == 0))) begin errs++; $display("[TB] FAIL frm_fstart %0d,%0d: got %b", expX, expY, fsB); end
      if ({rB, gB, bB} !== 12'h000) begin errs++; $display("[TB] FAIL frm_rgb: got %h expected 000", {rB, gB, bB}); end
      if (vsB !== prevVs && expX != 0) begin
        vecs++; errs++; $display("[TB] FAIL vsync_edge: got change at x=%0d expected x=0", expX);
      end
      prevVs = vsB;
    end
    vecs++;
    if (fcB !== 8'd2) begin errs++; $display("[TB] FAIL frm_fcnt: got %0d expected 2", fcB); end
  endtask

  // 256 frames on the small raster. frame_cnt steps once per frame, passes
  // 255 -> 0, and ends back where it started.
  task automatic test_wrap();
    int fsCount;
    logic [7:0] expFc;
    expFc = 8'd2;
    for (int f = 0; f < 256; f++) begin
      fsCount = 0;
      repeat (160) begin
        stepCycle();
        if (fsB === 1'b1) fsCount++;
      end
      expFc = expFc + 8'd1;
      vecs += 3;
      if (fsCount != 1) begin errs++; $display("[TB] FAIL wrap_fs_count f=%0d: got %0d expected 1", f, fsCount); end
      if (fcB !== expFc) begin errs++; $display("[TB] FAIL wrap_fcnt f=%0d: got %0d expected %0d", f, fcB, expFc); end
      if (xB !== 10'd0 || yB !== 10'd0) begin errs++; $display("[TB] FAIL wrap_xy f=%0d: got %0d,%0d expected 0,0", f, xB, yB); end
    end
    vecs++;
    if (fcB !== 8'd2) begin errs++; $display("[TB] FAIL wrap_final: got %0d expected 2", fcB); end
  endtask

  // Reset in mid-frame at (5,3), while vsync is idle.
  task automatic test_mid_reset();
    repeat (53) stepCycle();
    vecs++;
    if (xB !== 10'd5 || yB !== 10'd3 || vsB !== 1'b0) begin
      errs++; $display("[TB] FAIL mid_pos: got %0d,%0d vs=%b expected 5,3,0", xB, yB, vsB);
    end
    rstB_n = 1'b0;
    stepCycle();
    vecs += 3;
    if (xB !== 10'd15 || yB !== 10'd9) begin errs++; $display("[TB] FAIL mid_rst_xy: got %0d,%0d expected 15,9", xB, yB); end
    if (fcB !== 8'd0 || actB !== 1'b0) begin errs++; $display("[TB] FAIL mid_rst_fc_act: got fc=%0d act=%b expected 0/0", fcB, actB); end
    if (hsB !== 1'b0 || vsB !== 1'b0 || lsB !== 1'b0 || fsB !== 1'b0) begin
      errs++; $display("[TB] FAIL mid_rst_flags: got hs=%b vs=%b ls=%b fs=%b expected 0000", hsB, vsB, lsB, fsB);
    end
    rstB_n = 1'b1;
    stepCycle();
    vecs += 2;
    if (xB !== 10'd0 || yB !== 10'd0 || fcB !== 8'd1) begin errs++; $display("[TB] FAIL mid_rel_state: got %0d,%0d fc=%0d expected 0,0,1", xB, yB, fcB); end
    if (fsB !== 1'b1 || lsB !== 1'b1 || actB !== 1'b1) begin errs++; $display("[TB] FAIL mid_rel_flags: got fs=%b ls=%b act=%b expected 111", fsB, lsB, actB); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rstA_n = 1'b0;
    rstB_n = 1'b0;
    test_reset();
    test_hline();
    test_frame();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
